// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand request and busy/done/result response bundle
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
  modport master (output start, a, b, ci, input busy, done, sum, co);
  modport slave  (input start, a, b, ci, output busy, done, sum, co);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell reused LSB-first over WIDTH cycles
module fulladder (
  output logic sum,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(parameter int WIDTH = 8) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d, shift_b_q, shift_b_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_n, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, co_q, co_d;
  logic             fa_sum, fa_co;
  fulladder u_fa (
    .sum (fa_sum),
    .co  (fa_co),
    .a   (shift_a_q[0]),
    .b   (shift_b_q[0]),
    .ci  (carry_q)
  );
  // new bit enters at the MSB so after WIDTH cycles bit 0 has reached acc[0]
  assign acc_n = WIDTH'({fa_sum, acc_q} >> 1);
  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    co_d      = co_q;
    if (bus.start && state_q != ADD) begin
      state_d   = ADD;
      shift_a_d = bus.a;
      shift_b_d = bus.b;
      carry_d   = bus.ci;
      cnt_d     = '0;
      acc_d     = '0;
    end else if (state_q == ADD) begin
      shift_a_d = shift_a_q >> 1;
      shift_b_d = shift_b_q >> 1;
      acc_d     = acc_n;
      carry_d   = fa_co;
      cnt_d     = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        sum_d   = acc_n;
        co_d    = fa_co;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      co_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      co_q      <= co_d;
    end
  end
  assign bus.busy = state_q == ADD;
  assign bus.done = state_q == DONE;
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for 8-bit and 4-bit serial adders against a + b + ci
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  serial_adder_if #(.WIDTH(8)) s8();
  serial_adder_if #(.WIDTH(4)) s4();
  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(s8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(s4));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("s8_busy_done_excl", {31'd0, s8.busy & s8.done}, 32'd0);
    if (s8.done) begin
      if (q8.size() == 0) chk("s8_unexpected_done", 32'd1, 32'd0);
      else chk("s8_result", {23'd0, s8.co, s8.sum}, {23'd0, q8.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (s4.done) begin
      if (q4.size() == 0) chk("s4_unexpected_done", 32'd1, 32'd0);
      else chk("s4_result", {27'd0, s4.co, s4.sum}, {27'd0, q4.pop_front()});
    end
  end

  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return 9'(int'(a) + int'(b) + int'(c));
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit hold);
    s8.a = a; s8.b = b; s8.ci = c; s8.start = 1'b1;
    q8.push_back(ref8(a, b, c));
    @(posedge clk); #1;
    if (!hold) s8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s8_busy_in_add", {31'd0, s8.busy}, 32'd1);
      @(posedge clk); #1;
    end
    chk("s8_done_latency", {30'd0, s8.done, s8.busy}, 32'd2);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int n = 0;
    s4.a = a; s4.b = b; s4.ci = c; s4.start = 1'b1;
    q4.push_back(5'(int'(a) + int'(b) + int'(c)));
    @(posedge clk); #1;
    s4.start = 1'b0;
    while (!s4.done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s4_latency", n, 4);
  endtask

  initial begin
    s8.start = 1'b0; s8.a = '0; s8.b = '0; s8.ci = 1'b0;
    s4.start = 1'b0; s4.a = '0; s4.b = '0; s4.ci = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s8", {21'd0, s8.busy, s8.done, s8.co, s8.sum}, 32'd0);
    chk("reset_s4", {25'd0, s4.busy, s4.done, s4.co, s4.sum}, 32'd0);
    rst_n = 1'b1;
    op8(8'h3C, 8'h5A, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", {30'd0, s8.done, s8.busy}, 32'd0);
    chk("sum_held", {23'd0, s8.co, s8.sum}, 32'h096);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    op8(8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    // start during ADD must be ignored
    s8.a = 8'h3C; s8.b = 8'h5A; s8.ci = 1'b0; s8.start = 1'b1;
    q8.push_back(ref8(8'h3C, 8'h5A, 1'b0));
    @(posedge clk); #1;
    s8.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    s8.a = 8'h01; s8.b = 8'h01; s8.start = 1'b1;
    @(posedge clk); #1;
    s8.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("ignored_start_done", {31'd0, s8.done}, 32'd1);
    @(posedge clk); #1;
    chk("ignored_start_no_restart", {30'd0, s8.done, s8.busy}, 32'd0);
    // reset mid-ADD
    s8.a = 8'h12; s8.b = 8'h34; s8.ci = 1'b1; s8.start = 1'b1;
    @(posedge clk); #1;
    s8.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("busy_before_reset", {31'd0, s8.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear", {21'd0, s8.busy, s8.done, s8.co, s8.sum}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("no_done_after_reset", {30'd0, s8.done, s8.busy}, 32'd0);
      @(posedge clk); #1;
    end
    op8(8'hA5, 8'h5B, 1'b1, 1'b0);
    // back-to-back with start held high, new operands each DONE cycle
    for (int k = 0; k < 6; k++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    s8.start = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          op4(4'(a), 4'(b), 1'(c));
    repeat (3) @(posedge clk);
    #1;
    chk("s8_queue_drained", q8.size(), 0);
    chk("s4_queue_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
